// File: rtl/lru_ctrl.sv
// lru_ctrl: tree-PLRU read-modify-write controller for a 4-way cache, 2-stage pipeline.
// Optional hit/miss counters are enabled with `define LRU_CTRL_STATS_EN.
module lru_ctrl #(
  parameter int S_INDEX = 4
`ifdef LRU_CTRL_STATS_EN
  , parameter int STAT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [S_INDEX-1:0] req_set,
  input  logic               req_hit,
  input  logic [1:0]         req_way,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [1:0]         resp_way,
  output logic [1:0]         resp_victim,
  output logic               lru_csb0,
  output logic               lru_web0,
  output logic [S_INDEX-1:0] lru_addr0,
  input  logic [2:0]         lru_dout0,
  output logic               lru_csb1,
  output logic               lru_web1,
  output logic [S_INDEX-1:0] lru_addr1,
  output logic [2:0]         lru_din1
`ifdef LRU_CTRL_STATS_EN
  , output logic [STAT_W-1:0] hit_cnt,
  output logic [STAT_W-1:0]  miss_cnt
`endif
);
  logic               r_s2_valid;
  logic               r_s2_hit;
  logic [1:0]         r_s2_way;
  logic [S_INDEX-1:0] r_s2_set;
  logic               w_fire;
  logic               w_acc;
  logic [1:0]         w_victim;
  logic [1:0]         w_way;
  logic [2:0]         w_new;
  assign w_fire      = r_s2_valid && resp_ready;
  assign req_ready   = !r_s2_valid || resp_ready;
  assign w_acc       = req_valid && req_ready;
  assign w_victim    = lru_dout0[0] ? {1'b1, lru_dout0[2]} : {1'b0, lru_dout0[1]};
  assign w_way       = r_s2_hit ? r_s2_way : w_victim;
  assign w_new       = w_way[1] ? {~w_way[0], lru_dout0[1], 1'b0} : {lru_dout0[2], ~w_way[0], 1'b1};
  assign resp_valid  = r_s2_valid;
  assign resp_victim = r_s2_valid ? w_victim : 2'd0;
  assign resp_way    = r_s2_valid ? w_way : 2'd0;
  assign lru_web0    = 1'b1;
  assign lru_csb0    = rst || !w_acc;
  assign lru_addr0   = (w_acc && !rst) ? req_set : '0;
  assign lru_csb1    = rst || !w_fire;
  assign lru_web1    = rst || !w_fire;
  assign lru_addr1   = (w_fire && !rst) ? r_s2_set : '0;
  assign lru_din1    = (w_fire && !rst) ? w_new : 3'd0;
  // Stage-2 request registers: load on accept, drain on fire, hold on stall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_hit   <= 1'b0;
      r_s2_way   <= 2'd0;
      r_s2_set   <= '0;
    end else if (w_acc) begin
      r_s2_valid <= 1'b1;
      r_s2_hit   <= req_hit;
      r_s2_way   <= req_way;
      r_s2_set   <= req_set;
    end else if (w_fire) begin
      r_s2_valid <= 1'b0;
    end
  end
`ifdef LRU_CTRL_STATS_EN
  logic [STAT_W-1:0] r_hit_cnt;
  logic [STAT_W-1:0] r_miss_cnt;
  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
  // Saturating hit/miss counters, bumped once per fired response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_fire) begin
      if (r_s2_hit && r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
      if (!r_s2_hit && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end
`endif
endmodule
